audio_mix_scaler: RTL and testbench

- Parametrised successor to the single-channel synth-to-DAC scaler.
- Takes NUM_CH signed synth sample streams in parallel and applies a per-channel left shift (gain).
- Gain changes ramp one step per sample to avoid clicks.
- Channels are summed, rescaled to OUT_W bits and converted to an offset-binary DAC code.
- Sits between the synth voices and the PWM/DAC driver, with a valid/ready stream on both sides.

---
 rtl/audio_mix_scaler.sv | 124 ++++++++++++
 tb/tb_audio_mix_scaler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_scaler.sv
// Multi-channel synth mixer: per-channel ramped left-shift gain, summation and
// rescale to an offset-binary DAC code. Define AUDIO_MIX_SCALER_SAT_EN for saturating arithmetic.
module audio_mix_scaler #(
  parameter int NUM_CH  = 2,
  parameter int IN_W    = 14,
  parameter int OUT_W   = 10,
  parameter int SHIFT_W = 5,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*IN_W-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  output logic [OUT_W-1:0]         out_code,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int SUM_W = IN_W + $clog2(NUM_CH);
  localparam int DROP  = IN_W - OUT_W;
  localparam logic [OUT_W-1:0] CODE_MSB = {1'b1, {(OUT_W-1){1'b0}}};

`ifdef AUDIO_MIX_SCALER_SAT_EN
  localparam int W2 = 2 * IN_W;
  localparam logic signed [IN_W-1:0]  P_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0]  P_MIN = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] T_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] T_MIN = SUM_W'(-(2 ** (OUT_W - 1)));
`endif

  logic                     adv_s;
  logic                     accept_s;
  logic                     s1_valid_r;
  logic signed [IN_W-1:0]   p_r   [NUM_CH];
  logic [SHIFT_W-1:0]       cur_r [NUM_CH];
  logic [SHIFT_W-1:0]       tgt_r [NUM_CH];
  logic signed [SUM_W-1:0]  sum_s;

  function automatic logic signed [IN_W-1:0] gain_apply(
    input logic signed [IN_W-1:0] x,
    input logic [SHIFT_W-1:0]     sh
  );
`ifdef AUDIO_MIX_SCALER_SAT_EN
    if (x == '0) gain_apply = '0;
    else if (32'(sh) >= IN_W) gain_apply = x[IN_W-1] ? P_MIN : P_MAX;
    else if ((W2'(x) <<< sh) > W2'(P_MAX)) gain_apply = P_MAX;
    else if ((W2'(x) <<< sh) < W2'(P_MIN)) gain_apply = P_MIN;
    else gain_apply = x <<< sh;
`else
    if (32'(sh) >= IN_W) gain_apply = '0;
    else gain_apply = x <<< sh;
`endif
  endfunction

  // Floor-divide the mix down to OUT_W bits and flip the MSB for offset binary.
  function automatic logic [OUT_W-1:0] to_code(input logic signed [SUM_W-1:0] s);
`ifdef AUDIO_MIX_SCALER_SAT_EN
    if ((s >>> DROP) > T_MAX) to_code = '1;
    else if ((s >>> DROP) < T_MIN) to_code = '0;
    else to_code = OUT_W'(s >>> DROP) ^ CODE_MSB;
`else
    to_code = OUT_W'(s >>> DROP) ^ CODE_MSB;
`endif
  endfunction

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;
  assign accept_s = in_valid && adv_s;

  always_comb begin
    sum_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum_s = sum_s + SUM_W'(p_r[c]);
    end
  end

  // Two-stage data pipeline; out_code only changes when a valid sum arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      out_valid  <= 1'b0;
      out_code   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        p_r[c] <= '0;
      end
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      out_valid  <= s1_valid_r;
      if (s1_valid_r) begin
        out_code <= to_code(sum_s);
      end
      if (in_valid) begin
        for (int c = 0; c < NUM_CH; c++) begin
          p_r[c] <= gain_apply(in_data[c*IN_W +: IN_W], cur_r[c]);
        end
      end
    end
  end

  // Gain ramp steps only on accepted samples; targets written any cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cur_r[c] <= '0;
        tgt_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept_s) begin
          if (cur_r[c] < tgt_r[c]) cur_r[c] <= cur_r[c] + SHIFT_W'(1);
          else if (cur_r[c] > tgt_r[c]) cur_r[c] <= cur_r[c] - SHIFT_W'(1);
        end
        if (cfg_we && cfg_ch == CH_W'(c)) begin
          tgt_r[c] <= cfg_shift;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_mix_scaler.sv
// Self-checking bench for audio_mix_scaler: directed literal cases plus
// randomized traffic scored against an arithmetic reference model.
module tb_audio_mix_scaler;

  localparam int NUM_CH  = 2;
  localparam int IN_W    = 14;
  localparam int OUT_W   = 10;
  localparam int SHIFT_W = 5;
  localparam int CH_W    = 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_CH*IN_W-1:0] in_data = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   cfg_we = 1'b0;
  logic [CH_W-1:0]        cfg_ch = '0;
  logic [SHIFT_W-1:0]     cfg_shift = '0;
  logic [OUT_W-1:0]       out_code;
  logic                   out_valid;
  logic                   out_ready = 1'b1;

  audio_mix_scaler #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_shift(cfg_shift),
    .out_code(out_code), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int cur_m[NUM_CH];
  int tgt_m[NUM_CH];
  int delivered = 0;
  bit armed = 1'b0;
  bit prev_rst = 1'b0;
  bit prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_code;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: true product, then wrap or clamp, exact sum, floor division, offset.
  function automatic int model_code(input logic [NUM_CH*IN_W-1:0] d);
    longint s, x, p, t;
    s = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      x = longint'($signed(d[c*IN_W +: IN_W]));
      p = x * (longint'(1) << cur_m[c]);
`ifdef AUDIO_MIX_SCALER_SAT_EN
      if (p > 2 ** (IN_W - 1) - 1) p = 2 ** (IN_W - 1) - 1;
      if (p < -(2 ** (IN_W - 1))) p = -(2 ** (IN_W - 1));
`else
      p = p & ((longint'(1) << IN_W) - 1);
      if (p >= 2 ** (IN_W - 1)) p = p - 2 ** IN_W;
`endif
      s = s + p;
    end
    t = s >>> (IN_W - OUT_W);
`ifdef AUDIO_MIX_SCALER_SAT_EN
    if (t > 2 ** (OUT_W - 1) - 1) t = 2 ** (OUT_W - 1) - 1;
    if (t < -(2 ** (OUT_W - 1))) t = -(2 ** (OUT_W - 1));
`endif
    return int'((t + 2 ** (OUT_W - 1)) & (2 ** OUT_W - 1));
  endfunction

  // Compare process: invariants every cycle, scoreboard on each output handshake.
  always @(posedge clk) begin
    if (armed) begin
      if (prev_rst) begin
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_code", 32'(out_code), 32'd0);
      end else begin
        chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (prev_stall) begin
          chk("stall_hold_valid", 32'(out_valid), 32'd1);
          chk("stall_hold_code", 32'(out_code), 32'(prev_code));
        end
      end
    end
    if (!rst_n) begin
      armed = 1'b1;
      exp_q.delete();
      for (int c = 0; c < NUM_CH; c++) begin
        cur_m[c] = 0;
        tgt_m[c] = 0;
      end
    end else if (armed) begin
      if (out_valid && out_ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(out_code), 32'hFFFF_FFFF);
        end else begin
          chk("stream_code", 32'(out_code), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_code(in_data));
        for (int c = 0; c < NUM_CH; c++) begin
          if (cur_m[c] < tgt_m[c]) cur_m[c]++;
          else if (cur_m[c] > tgt_m[c]) cur_m[c]--;
        end
      end
      if (cfg_we && int'(cfg_ch) < NUM_CH) tgt_m[int'(cfg_ch)] = int'(cfg_shift);
    end
    prev_rst   = !rst_n;
    prev_stall = rst_n && out_valid && !out_ready;
    prev_code  = out_code;
  end

  task automatic cfg(input int ch, input int sh);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_shift = SHIFT_W'(sh);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int exp, input string nm);
    @(negedge clk);
    in_data = {IN_W'(b), IN_W'(a)};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk(nm, 32'(out_code), 32'(exp));
  endtask

  task automatic drain(input string nm);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int i, d0;
    bit need_new;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_out_code", 32'(out_code), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd1);

    send(1000, 0, 574, "pos1000");
    send(-1000, 0, 449, "neg1000");

    cfg(0, 3);
    send(16, 0, 513, "ramp_up0");
    send(16, 0, 514, "ramp_up1");
    send(16, 0, 516, "ramp_up2");
    send(16, 0, 520, "ramp_up3");
    send(16, 0, 520, "ramp_up4");
    cfg(0, 0);
    send(16, 0, 520, "ramp_dn3");
    send(16, 0, 516, "ramp_dn2");
    send(16, 0, 514, "ramp_dn1");
    send(16, 0, 513, "ramp_dn0");

    cfg(0, 2);
    send(0, 0, 512, "zero_a");
    send(0, 0, 512, "zero_b");
`ifdef AUDIO_MIX_SCALER_SAT_EN
    send(4096, 0, 1023, "ovf_shift2");
`else
    send(4096, 0, 512, "ovf_shift2");
`endif
    cfg(0, 0);
    send(0, 0, 512, "zero_c");
    send(0, 0, 512, "zero_d");
`ifdef AUDIO_MIX_SCALER_SAT_EN
    send(8191, 8191, 1023, "sum_max");
    send(-8192, -8192, 0, "sum_min");
`else
    send(8191, 8191, 511, "sum_max");
    send(-8192, -8192, 512, "sum_min");
`endif

    // Streaming with a 3-cycle output stall while channel 1 ramps.
    cfg(1, 4);
    drain("pre_stream_drain");
    d0 = delivered;
    i = 0;
    need_new = 1'b1;
    for (int cyc = 0; cyc < 60 && i < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 6);
      if (need_new) begin
        in_data = (NUM_CH*IN_W)'({$urandom, $urandom});
        need_new = 1'b0;
      end
      in_valid = 1'b1;
      #1;
      if (cyc >= 3 && cyc < 6) chk("stall_in_ready_low", 32'(in_ready), 32'd0);
      if (in_ready) begin
        i++;
        need_new = 1'b1;
      end
    end
    @(negedge clk);
    drain("stream_drain");
    chk("stream_count", 32'(delivered - d0), 32'd8);
    cfg(1, 0);
    repeat (4) send(0, 0, 512, "ch1_ramp_home");

    // Reset with two samples in flight and shift 2 active.
    cfg(0, 2);
    send(0, 0, 512, "pre_rst_a");
    send(0, 0, 512, "pre_rst_b");
    @(negedge clk);
    in_data = {IN_W'(0), IN_W'(1000)};
    in_valid = 1'b1;
    @(negedge clk);
    in_data = {IN_W'(0), IN_W'(2000)};
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_code", 32'(out_code), 32'd0);
    send(1000, 0, 574, "post_rst_shift0");
    send(1000, 0, 574, "post_rst_tgt0");

    // Randomized traffic: back-pressure, config writes, shifts past IN_W.
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = (NUM_CH*IN_W)'({$urandom, $urandom});
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_shift = SHIFT_W'($urandom_range(0, 16));
    end
    @(negedge clk);
    cfg_we = 1'b0;
    drain("random_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
